// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative 32-step multiply/divide unit
// that owns HI/LO and stalls the front end while it runs.
module ex_stage #(
  parameter int unsigned MD_STEPS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] valA_in,
  input  logic [31:0] valB_in,
  input  logic [31:0] offset_in,
  input  logic [4:0]  dest_in,
  input  logic [5:0]  op_in,
  input  logic [7:0]  signals_in,
  output logic        stall_out,
  output logic        out_valid,
  output logic [31:0] pc_out,
  output logic [31:0] result_out,
  output logic [31:0] store_out,
  output logic [4:0]  dest_out,
  output logic [7:0]  signals_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_AND  = 6'd2,  OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4,  OP_NOR  = 6'd5,  OP_SLT  = 6'd6,  OP_SLTU = 6'd7;
  localparam logic [5:0] OP_SLL  = 6'd8,  OP_SRL  = 6'd9,  OP_SRA  = 6'd10, OP_LUI  = 6'd11;
  localparam logic [5:0] OP_MULT = 6'd16, OP_MULTU = 6'd17, OP_DIV = 6'd18, OP_DIVU = 6'd19;
  localparam logic [5:0] OP_MFHI = 6'd20, OP_MFLO = 6'd21;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d, result_q, result_d, store_q, store_d;
  logic [4:0]  dest_q, dest_d;
  logic [7:0]  sig_q, sig_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] w_q, w_d;
  logic [31:0] m_q, m_d, araw_q, araw_d;
  logic        is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic [31:0] pc_c_q, pc_c_d, store_c_q, store_c_d;
  logic [4:0]  dest_c_q, dest_c_d;
  logic [7:0]  sig_c_q, sig_c_d;

  logic [31:0] b_op, alu_res, mag_a, mag_b;
  logic        is_md, is_signed, sa, sb, last;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] w_step, prod;

  assign b_op      = signals_in[0] ? offset_in : valB_in;
  assign is_md     = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                     (op_in == OP_DIV)  || (op_in == OP_DIVU);
  assign is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign sa        = is_signed & valA_in[31];
  assign sb        = is_signed & b_op[31];
  assign mag_a     = sa ? -valA_in : valA_in;
  assign mag_b     = sb ? -b_op : b_op;
  assign last      = (cnt_q == 5'(MD_STEPS - 1));
  assign stall_out = (state_q == BUSY) || (in_valid && is_md);

  always_comb begin
    alu_res = '0;
    case (op_in)
      OP_ADD:  alu_res = valA_in + b_op;
      OP_SUB:  alu_res = valA_in - b_op;
      OP_AND:  alu_res = valA_in & b_op;
      OP_OR:   alu_res = valA_in | b_op;
      OP_XOR:  alu_res = valA_in ^ b_op;
      OP_NOR:  alu_res = ~(valA_in | b_op);
      OP_SLT:  alu_res = {31'b0, $signed(valA_in) < $signed(b_op)};
      OP_SLTU: alu_res = {31'b0, valA_in < b_op};
      OP_SLL:  alu_res = b_op << valA_in[4:0];
      OP_SRL:  alu_res = b_op >> valA_in[4:0];
      OP_SRA:  alu_res = $signed(b_op) >>> valA_in[4:0];
      OP_LUI:  alu_res = {b_op[15:0], 16'h0};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Mul: {acc, multiplier} shifts right, adding the multiplicand on a 1 LSB.
  // Div: {remainder, dividend} shifts left, quotient bits fill in from the LSB.
  always_comb begin
    mul_sum  = {1'b0, w_q[63:32]} + {1'b0, m_q};
    div_diff = w_q[63:31] - {1'b0, m_q};
    if (is_div_q) begin
      if (!div_diff[32]) w_step = {div_diff[31:0], w_q[30:0], 1'b1};
      else               w_step = {w_q[62:0], 1'b0};
    end else begin
      if (w_q[0]) w_step = {mul_sum, w_q[31:1]};
      else        w_step = {1'b0, w_q[63:1]};
    end
    prod = neg_q ? -w_step : w_step;
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    result_d  = result_q;
    store_d   = store_q;
    dest_d    = dest_q;
    sig_d     = sig_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    m_d       = m_q;
    araw_d    = araw_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    pc_c_d    = pc_c_q;
    store_c_d = store_c_q;
    dest_c_d  = dest_c_q;
    sig_c_d   = sig_c_q;
    case (state_q)
      IDLE: begin
        valid_d  = in_valid && !is_md;
        pc_d     = pc_in;
        result_d = alu_res;
        store_d  = valB_in;
        dest_d   = dest_in;
        sig_d    = signals_in;
        if (in_valid && is_md) begin
          state_d   = BUSY;
          cnt_d     = '0;
          is_div_d  = (op_in == OP_DIV) || (op_in == OP_DIVU);
          neg_d     = sa ^ sb;
          rneg_d    = sa;
          araw_d    = valA_in;
          pc_c_d    = pc_in;
          store_c_d = valB_in;
          dest_c_d  = dest_in;
          sig_c_d   = signals_in;
          if (is_div_d) begin
            w_d = {32'b0, mag_a};
            m_d = mag_b;
          end else begin
            w_d = {32'b0, mag_b};
            m_d = mag_a;
          end
        end
      end
      BUSY: begin
        valid_d = 1'b0;
        w_d     = w_step;
        cnt_d   = cnt_q + 5'd1;
        if (last) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          result_d = '0;
          pc_d     = pc_c_q;
          store_d  = store_c_q;
          dest_d   = dest_c_q;
          sig_d    = sig_c_q;
          if (!is_div_q) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (m_q == '0) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            lo_d = neg_q  ? -w_step[31:0]  : w_step[31:0];
            hi_d = rneg_q ? -w_step[63:32] : w_step[63:32];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      result_q  <= '0;
      store_q   <= '0;
      dest_q    <= '0;
      sig_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      w_q       <= '0;
      m_q       <= '0;
      araw_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      pc_c_q    <= '0;
      store_c_q <= '0;
      dest_c_q  <= '0;
      sig_c_q   <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      result_q  <= result_d;
      store_q   <= store_d;
      dest_q    <= dest_d;
      sig_q     <= sig_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      m_q       <= m_d;
      araw_q    <= araw_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      pc_c_q    <= pc_c_d;
      store_c_q <= store_c_d;
      dest_c_q  <= dest_c_d;
      sig_c_q   <= sig_c_d;
    end
  end

  assign out_valid   = valid_q;
  assign pc_out      = pc_q;
  assign result_out  = result_q;
  assign store_out   = store_q;
  assign dest_out    = dest_q;
  assign signals_out = sig_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, iterative mul/div, stall length, reset abort.
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc_in, valA_in, valB_in, offset_in;
  logic [4:0]  dest_in;
  logic [5:0]  op_in;
  logic [7:0]  signals_in;
  logic        stall_out, out_valid;
  logic [31:0] pc_out, result_out, store_out, hi_out, lo_out;
  logic [4:0]  dest_out;
  logic [7:0]  signals_out;

  int checks = 0;
  int failures = 0;
  int n;
  logic seen;

  ex_stage #(.MD_STEPS(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .pc_in(pc_in),
    .valA_in(valA_in), .valB_in(valB_in), .offset_in(offset_in), .dest_in(dest_in),
    .op_in(op_in), .signals_in(signals_in), .stall_out(stall_out), .out_valid(out_valid),
    .pc_out(pc_out), .result_out(result_out), .store_out(store_out), .dest_out(dest_out),
    .signals_out(signals_out), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] off, input logic [7:0] sig, input logic [31:0] pc,
                       input logic [4:0] dst);
    in_valid = v; op_in = op; valA_in = a; valB_in = b;
    offset_in = off; signals_in = sig; pc_in = pc; dest_in = dst;
  endtask

  task automatic alu(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] off, input logic [7:0] sig, input logic [31:0] exp);
    drive(1'b1, op, a, b, off, sig, 32'h400, 5'd9);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, result_out, exp);
  endtask

  task automatic md(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ehi, input logic [31:0] elo);
    int cnt;
    drive(1'b1, op, a, b, 32'h0, 8'h0, 32'h200, 5'd4);
    #1;
    cnt = 0;
    while (stall_out === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
      drive(1'b0, 6'd0, 32'h0, 32'h0, 32'h0, 8'h0, 32'h0, 5'd0);
    end
    chk({tag, "_stall_cycles"}, cnt, 33);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, result_out, 0);
    chk({tag, "_pc"}, pc_out, 32'h200);
    chk({tag, "_hi"}, hi_out, ehi);
    chk({tag, "_lo"}, lo_out, elo);
    tick();
    chk({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 6'd0, 32'h0, 32'h0, 32'h0, 8'h0, 32'h0, 5'd0);
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_stall", stall_out, 0);
    reset = 1'b0;

    drive(1'b1, 6'd0, 32'd5, 32'd7, 32'h0, 8'h0, 32'h100, 5'd3);
    #1;
    chk("add_stall", stall_out, 0);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_result", result_out, 12);
    chk("add_pc", pc_out, 32'h100);
    chk("add_dest", dest_out, 3);
    chk("add_store", store_out, 7);

    alu("sub", 6'd1, 32'd5, 32'd7, 32'h0, 8'h0, 32'hFFFF_FFFE);
    alu("nor", 6'd5, 32'h0, 32'h0, 32'h0, 8'h0, 32'hFFFF_FFFF);
    alu("slt", 6'd6, 32'hFFFF_FFFF, 32'd1, 32'h0, 8'h0, 32'd1);
    alu("sltu", 6'd7, 32'hFFFF_FFFF, 32'd1, 32'h0, 8'h0, 32'd0);
    alu("sll", 6'd8, 32'd4, 32'd1, 32'h0, 8'h0, 32'd16);
    alu("srl", 6'd9, 32'd31, 32'h8000_0000, 32'h0, 8'h0, 32'd1);
    alu("sra", 6'd10, 32'd31, 32'h8000_0000, 32'h0, 8'h0, 32'hFFFF_FFFF);
    alu("lui", 6'd11, 32'h0, 32'h1234_ABCD, 32'h0, 8'h0, 32'hABCD_0000);
    alu("badop", 6'd63, 32'd3, 32'd3, 32'h0, 8'h0, 32'd0);
    drive(1'b1, 6'd0, 32'd1, 32'h1234, 32'hFFFF_FFFF, 8'h01, 32'h500, 5'd7);
    tick();
    chk("alusrc_result", result_out, 0);
    chk("alusrc_store", store_out, 32'h1234);
    chk("alusrc_sig", signals_out, 8'h01);
    drive(1'b0, 6'd0, 32'd1, 32'd1, 32'h0, 8'h0, 32'h0, 5'd0);
    tick();
    chk("bubble_valid", out_valid, 0);

    md("mult", 6'd16, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    md("multu", 6'd17, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'hFFFF_FFFA);
    alu("mfhi", 6'd20, 32'h0, 32'h0, 32'h0, 8'h0, 32'd2);

    drive(1'b1, 6'd16, 32'd4, 32'd5, 32'h0, 8'h0, 32'h200, 5'd4);
    #1;
    chk("mflo_accept_stall", stall_out, 1);
    tick();
    drive(1'b1, 6'd21, 32'h0, 32'h0, 32'h0, 8'h0, 32'h300, 5'd2);
    n = 1;
    while (stall_out === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("mflo_stall_cycles", n, 33);
    chk("mflo_mul_valid", out_valid, 1);
    chk("mflo_mul_lo", lo_out, 20);
    tick();
    chk("mflo_valid", out_valid, 1);
    chk("mflo_result", result_out, 20);
    chk("mflo_pc", pc_out, 32'h300);

    md("div_neg", 6'd18, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md("divu_zero", 6'd19, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    md("div_ovf", 6'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    md("div_zero_neg", 6'd18, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    drive(1'b1, 6'd16, 32'd3, 32'd3, 32'h0, 8'h0, 32'h600, 5'd1);
    tick();
    drive(1'b0, 6'd0, 32'h0, 32'h0, 32'h0, 8'h0, 32'h0, 5'd0);
    repeat (10) tick();
    chk("abort_busy_stall", stall_out, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_stall", stall_out, 0);
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    chk("abort_valid", out_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0 || stall_out !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_pulse", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
